// File: rtl/verify_round_sequencer_if.sv
// Signal bundle between the round sequencer (master) and its environment:
// pass control, upstream round fetch, responder drive and result stream.
interface verify_round_sequencer_if;
  // Pass control and status
  logic         verify_start;
  logic [7:0]   num_rounds;
  logic [255:0] salt;
  logic         busy;
  logic         verify_done;
  logic         verify_err;
  // Upstream round fetch: round_req is held until round_ack is seen
  logic         round_req;
  logic [7:0]   round_idx;
  logic         round_ack;
  logic [7:0]   round_j;
  logic [127:0] round_seed_star;
  logic [127:0] round_instseeds;
  // Responder start/end level handshake
  logic         rf_start;
  logic [7:0]   rf_t;
  logic [7:0]   rf_j;
  logic [127:0] rf_seed_star;
  logic [127:0] rf_instseeds;
  logic [255:0] rf_salt;
  logic         rf_end;
  logic [255:0] rf_ch;
  logic [255:0] rf_cn;
  // Result stream: a beat transfers on an edge where out_valid and out_ready are
  // both high; out_valid never drops and payload never changes before that edge.
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_round;
  logic [255:0] out_ch;
  logic [255:0] out_cn;

  modport master (
    input  verify_start, num_rounds, salt,
    output busy, verify_done, verify_err,
    output round_req, round_idx,
    input  round_ack, round_j, round_seed_star, round_instseeds,
    output rf_start, rf_t, rf_j, rf_seed_star, rf_instseeds, rf_salt,
    input  rf_end, rf_ch, rf_cn,
    output out_valid, out_round, out_ch, out_cn,
    input  out_ready
  );

  modport slave (
    output verify_start, num_rounds, salt,
    input  busy, verify_done, verify_err,
    input  round_req, round_idx,
    output round_ack, round_j, round_seed_star, round_instseeds,
    input  rf_start, rf_t, rf_j, rf_seed_star, rf_instseeds, rf_salt,
    output rf_end, rf_ch, rf_cn,
    input  out_valid, out_round, out_ch, out_cn,
    output out_ready
  );
endinterface

// File: rtl/verify_round_sequencer.sv
// Drives the per-round verify responder across all rounds of a verification pass,
// keeping one round in flight and streaming (round, Ch, Cn) results downstream.
module verify_round_sequencer #(
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  verify_round_sequencer_if.master    bus,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_RELEASE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  num_rounds_q;
  logic [19:0] wd;
  logic        wd_expired;
  logic        last_round;

  assign wd_expired = (wd == TIMEOUT - 20'd1);
  assign last_round = (bus.round_idx == num_rounds_q - 8'd1);
  assign dbg_state  = state;
  assign bus.rf_t   = bus.round_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // The watchdog wins over a completion seen on the same edge.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.verify_start)
                   state_nx = (bus.num_rounds == 8'd0) ? S_DONE : S_FETCH;
      S_FETCH:   if (bus.round_ack) state_nx = S_LAUNCH;
      S_LAUNCH:  if (wd_expired) state_nx = S_ERR;
                 else if (bus.rf_end) state_nx = S_RELEASE;
      S_RELEASE: if (wd_expired) state_nx = S_ERR;
                 else if (!bus.rf_end) state_nx = S_EMIT;
      S_EMIT:    if (bus.out_ready) state_nx = last_round ? S_DONE : S_FETCH;
      S_DONE,
      S_ERR:     if (!bus.verify_start) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.round_req   = 1'b0;
    bus.rf_start    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.busy        = 1'b0;
    bus.verify_done = 1'b0;
    bus.verify_err  = 1'b0;
    unique case (state)
      S_FETCH:   begin bus.round_req = 1'b1; bus.busy = 1'b1; end
      S_LAUNCH:  begin bus.rf_start  = 1'b1; bus.busy = 1'b1; end
      S_RELEASE: bus.busy = 1'b1;
      S_EMIT:    begin bus.out_valid = 1'b1; bus.busy = 1'b1; end
      S_DONE:    bus.verify_done = 1'b1;
      S_ERR:     begin bus.verify_done = 1'b1; bus.verify_err = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_rounds_q     <= '0;
      bus.rf_salt      <= '0;
      bus.round_idx    <= '0;
      bus.rf_j         <= '0;
      bus.rf_seed_star <= '0;
      bus.rf_instseeds <= '0;
      bus.out_round    <= '0;
      bus.out_ch       <= '0;
      bus.out_cn       <= '0;
      wd               <= '0;
    end else begin
      if (state == S_IDLE && bus.verify_start) begin
        num_rounds_q  <= bus.num_rounds;
        bus.rf_salt   <= bus.salt;
        bus.round_idx <= '0;
      end
      if (state == S_FETCH && bus.round_ack) begin
        bus.rf_j         <= bus.round_j;
        bus.rf_seed_star <= bus.round_seed_star;
        bus.rf_instseeds <= bus.round_instseeds;
        wd               <= '0;
      end
      if (state == S_LAUNCH || state == S_RELEASE) wd <= wd + 20'd1;
      if (state == S_LAUNCH && bus.rf_end && !wd_expired) begin
        bus.out_ch    <= bus.rf_ch;
        bus.out_cn    <= bus.rf_cn;
        bus.out_round <= bus.round_idx;
      end
      if (state == S_EMIT && bus.out_ready && !last_round)
        bus.round_idx <= bus.round_idx + 8'd1;
    end
  end

endmodule

// File: tb/tb_verify_round_sequencer.sv
// Directed bench for verify_round_sequencer with an upstream model, a responder
// model and a stream monitor; each scenario task checks its own outcomes.
module tb_verify_round_sequencer;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd6;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  verify_round_sequencer_if bus();

  verify_round_sequencer #(.TIMEOUT(20'd16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit never_end   = 1'b0;
  int hold_cycles = 1;
  int resp_delay  = 5;

  logic [7:0]   beat_round_q[$];
  logic [255:0] beat_ch_q[$];
  logic [255:0] beat_cn_q[$];
  int viol = 0, bad_latch = 0, req_seen = 0, start_seen = 0;
  int rel_cnt = 0, valid_while_end = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Upstream: acknowledges every request immediately with index-derived data.
  initial begin : upstream
    bus.round_ack       = 1'b0;
    bus.round_j         = '0;
    bus.round_seed_star = '0;
    bus.round_instseeds = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.round_ack       = reset && bus.round_req;
      bus.round_j         = 8'h10 + bus.round_idx;
      bus.round_seed_star = 128'h5000 + 128'(bus.round_idx);
      bus.round_instseeds = 128'h6000 + 128'(bus.round_idx);
    end
  end

  // Responder: raises rf_end resp_delay cycles after rf_start, drops it hold_cycles
  // cycles after rf_start falls.
  initial begin : responder
    int cnt;
    int hcnt;
    cnt = 0;
    hcnt = 0;
    bus.rf_end = 1'b0;
    bus.rf_ch  = '0;
    bus.rf_cn  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        bus.rf_end = 1'b0;
        cnt = 0;
        hcnt = 0;
      end else if (!bus.rf_end) begin
        hcnt = 0;
        if (bus.rf_start && !never_end) begin
          cnt++;
          if (cnt >= resp_delay) begin
            bus.rf_end = 1'b1;
            bus.rf_ch  = 256'h0A0 + 256'(bus.rf_t);
            bus.rf_cn  = 256'h0B0 + 256'(bus.rf_t);
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else if (!bus.rf_start) begin
        hcnt++;
        if (hcnt >= hold_cycles) begin
          bus.rf_end = 1'b0;
          hcnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic prev_end;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.out_valid && bus.out_ready) begin
          beat_round_q.push_back(bus.out_round);
          beat_ch_q.push_back(bus.out_ch);
          beat_cn_q.push_back(bus.out_cn);
        end
        if (bus.rf_start && bus.rf_end && prev_end) viol++;
        if (bus.round_req) req_seen++;
        if (bus.rf_start) start_seen++;
        if (bus.rf_start && (bus.rf_j !== 8'h10 + bus.rf_t ||
            bus.rf_seed_star !== 128'h5000 + 128'(bus.rf_t) ||
            bus.rf_instseeds !== 128'h6000 + 128'(bus.rf_t))) bad_latch++;
        if (dbg_state == ST_RELEASE) rel_cnt++;
        if (bus.out_valid && bus.rf_end) valid_while_end++;
      end
      prev_end = bus.rf_end;
    end
  end

  task automatic start_pass(input logic [7:0] n, input logic [255:0] s);
    bus.num_rounds   = n;
    bus.salt         = s;
    bus.verify_start = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (bus.verify_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.verify_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: verify_done=%b after %0d cycles, required 1", name, bus.verify_done, n);
    end
  endtask

  task automatic check_beats(input int n, input string name);
    checks++;
    if (beat_round_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: beats=%0d, required %0d", name, beat_round_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      if (beat_round_q.size() > 0) begin
        logic [7:0]   r;
        logic [255:0] ch;
        logic [255:0] cn;
        r  = beat_round_q.pop_front();
        ch = beat_ch_q.pop_front();
        cn = beat_cn_q.pop_front();
        checks++;
        if (r !== 8'(i) || ch !== 256'(32'hA0 + i) || cn !== 256'(32'hB0 + i)) begin
          errors++;
          $display("FAIL %s_beat%0d: round=%0d ch=%0h cn=%0h, required round=%0d ch=%0h cn=%0h",
                   name, i, r, ch[15:0], cn[15:0], i, 32'hA0 + i, 32'hB0 + i);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (dbg_state !== ST_IDLE || bus.busy !== 1'b0 || bus.verify_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d busy=%b done=%b, required 0 0 0", dbg_state, bus.busy, bus.verify_done);
    end
    checks++;
    if (bus.round_req !== 1'b0 || bus.rf_start !== 1'b0 || bus.out_valid !== 1'b0 || bus.verify_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: req=%b start=%b valid=%b err=%b, required all 0",
               bus.round_req, bus.rf_start, bus.out_valid, bus.verify_err);
    end
    checks++;
    if (bus.rf_salt !== '0 || bus.out_ch !== '0 || bus.round_idx !== 8'd0 || bus.rf_j !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: salt/ch/idx/j not all zero (idx=%0d j=%0d), required 0", bus.round_idx, bus.rf_j);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_three_rounds();
    int v0, b0;
    v0 = viol;
    b0 = bad_latch;
    beat_round_q.delete(); beat_ch_q.delete(); beat_cn_q.delete();
    bus.out_ready = 1'b1;
    start_pass(8'd3, 256'hC0FFEE);
    bus.salt = 256'hDEAD;
    bus.num_rounds = 8'd1;
    wait_done(200, "three_done");
    checks++;
    if (bus.verify_err !== 1'b0 || bus.rf_salt !== 256'hC0FFEE) begin
      errors++;
      $display("FAIL three_status: err=%b salt=%0h, required err=0 salt=c0ffee", bus.verify_err, bus.rf_salt[23:0]);
    end
    check_beats(3, "three");
    checks++;
    if (viol != v0 || bad_latch != b0) begin
      errors++;
      $display("FAIL three_handshake: start_during_end=%0d bad_latch=%0d, required 0 0", viol - v0, bad_latch - b0);
    end
    bus.verify_start = 1'b0;
    tick();
    checks++;
    if (bus.verify_done !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL three_release: done=%b state=%0d, required 0 0", bus.verify_done, dbg_state);
    end
  endtask

  task automatic test_zero_rounds();
    int r0, s0;
    r0 = req_seen;
    s0 = start_seen;
    start_pass(8'd0, 256'h1);
    checks++;
    if (bus.verify_done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, required 1 0", bus.verify_done, bus.busy);
    end
    tick();
    tick();
    checks++;
    if (req_seen != r0 || start_seen != s0) begin
      errors++;
      $display("FAIL zero_quiet: req cycles=%0d start cycles=%0d, required 0 0", req_seen - r0, start_seen - s0);
    end
    bus.verify_start = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    beat_round_q.delete(); beat_ch_q.delete(); beat_cn_q.delete();
    bus.out_ready = 1'b0;
    start_pass(8'd2, 256'h2);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: out_valid=%b after %0d cycles, required 1", bus.out_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 256'hA0 || bus.out_round !== 8'd0 || bus.round_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b ch=%0h round=%0d req=%b, required 1 a0 0 0",
                 i, bus.out_valid, bus.out_ch[15:0], bus.out_round, bus.round_req);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.round_req !== 1'b1 || bus.round_idx !== 8'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: req=%b idx=%0d valid=%b, required 1 1 0", bus.round_req, bus.round_idx, bus.out_valid);
    end
    wait_done(100, "bp_done");
    check_beats(2, "bp");
    bus.verify_start = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    int n;
    never_end = 1'b1;
    bus.out_ready = 1'b1;
    start_pass(8'd1, 256'h3);
    n = 0;
    while (bus.rf_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    repeat (15) tick();
    checks++;
    if (bus.verify_err !== 1'b0 || bus.rf_start !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: err=%b rf_start=%b at 15 cycles, required 0 1", bus.verify_err, bus.rf_start);
    end
    tick();
    checks++;
    if (bus.verify_err !== 1'b1 || bus.verify_done !== 1'b1 || bus.rf_start !== 1'b0 || dbg_state !== ST_ERR) begin
      errors++;
      $display("FAIL wd_expire: err=%b done=%b rf_start=%b state=%0d, required 1 1 0 6",
               bus.verify_err, bus.verify_done, bus.rf_start, dbg_state);
    end
    bus.verify_start = 1'b0;
    tick();
    checks++;
    if (bus.verify_err !== 1'b0 || bus.verify_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: err=%b done=%b, required 0 0", bus.verify_err, bus.verify_done);
    end
    never_end = 1'b0;
    tick();
  endtask

  task automatic test_release_hold();
    int r0, w0;
    hold_cycles = 4;
    r0 = rel_cnt;
    w0 = valid_while_end;
    beat_round_q.delete(); beat_ch_q.delete(); beat_cn_q.delete();
    bus.out_ready = 1'b1;
    start_pass(8'd1, 256'h4);
    wait_done(100, "hold_done");
    checks++;
    if (rel_cnt - r0 != 4 || valid_while_end != w0) begin
      errors++;
      $display("FAIL hold_release: release cycles=%0d valid_with_end=%0d, required 4 0", rel_cnt - r0, valid_while_end - w0);
    end
    check_beats(1, "hold");
    hold_cycles = 1;
    bus.verify_start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_round();
    int n;
    beat_round_q.delete(); beat_ch_q.delete(); beat_cn_q.delete();
    bus.out_ready = 1'b1;
    start_pass(8'd4, 256'h5);
    n = 0;
    while (!(bus.rf_start === 1'b1 && bus.rf_t === 8'd1) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rf_start !== 1'b1 || bus.rf_t !== 8'd1) begin
      errors++;
      $display("FAIL rst_reach: rf_start=%b rf_t=%0d, required 1 1", bus.rf_start, bus.rf_t);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rf_start !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_async: rf_start=%b busy=%b valid=%b state=%0d, required 0 0 0 0",
               bus.rf_start, bus.busy, bus.out_valid, dbg_state);
    end
    bus.verify_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    beat_round_q.delete(); beat_ch_q.delete(); beat_cn_q.delete();
    start_pass(8'd4, 256'h6);
    checks++;
    if (bus.round_idx !== 8'd0 || bus.round_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: idx=%0d req=%b, required 0 1", bus.round_idx, bus.round_req);
    end
    wait_done(300, "rst_done");
    check_beats(4, "rst");
    bus.verify_start = 1'b0;
    tick();
  endtask

  initial begin : global_bound
    #400000;
    $display("FAIL timeout: simulation bound reached, required completion");
    $fatal(1, "simulation bound reached");
  end

  initial begin
    reset            = 1'b0;
    bus.verify_start = 1'b0;
    bus.num_rounds   = '0;
    bus.salt         = '0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_three_rounds();
    test_zero_rounds();
    test_backpressure();
    test_watchdog();
    test_release_hold();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
